fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the program counter and presents it as a byte address to the instruction memory, which returns the word combinationally in the same cycle. It captures that word into the IF/ID pipeline register, and it handles stalls, flushes, control-flow redirects and end-of-program halt detection. Its output feeds the decode stage, and it receives stall, flush and redirect from the hazard/forwarding unit and the branch-resolution stage.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, drives the instruction memory
// address and captures the returned word into the IF/ID pipeline register.
// Latency: the word at pc in cycle N appears on ifid_* after edge N+1. Stall freezes everything.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   stall, flush, redirect_valid, redirect_pc      - hazard / branch-resolution controls
//   imem_addr (out), imem_data (in)               - combinational instruction memory
//   ifid_valid, ifid_instr, ifid_pc, ifid_pc_next - IF/ID register to decode
//   halted, fetch_count                           - status
//
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching on HALT_WORD.
// When it is undefined, HALT_WORD is an ordinary instruction and halted stays 0.
module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  PC_STEP   = 4,
    parameter logic [XLEN-1:0]  HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [XLEN-1:0]  NOP_WORD  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_next,
    output logic            halted,
    output logic [31:0]     fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic {RUN, HALTED} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] ipc_next_q, ipc_next_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] pc_plus;
    logic            halt_hit;

    assign pc_plus  = pc_q + PC_STEP;   // wraps modulo 2^XLEN
    // Without the feature this is constant 0 and the HALTED state is unreachable.
    assign halt_hit = HALT_EN && (imem_data == HALT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_WORD;
            ipc_q      <= '0;
            ipc_next_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            ipc_next_q <= ipc_next_d;
            count_q    <= count_d;
        end
    end

    // Priority: redirect > flush > stall > halted > normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        ipc_next_d = ipc_next_q;
        count_d    = count_q;

        if (redirect_valid) begin
            // Also cancels a halt that was fetched down a wrong path.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            state_d = RUN;
        end else if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            if (state_q == RUN) begin
                pc_d = pc_plus;
            end
        end else if (stall) begin
            // hold everything
        end else if (state_q == HALTED) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else begin
            valid_d    = 1'b1;
            instr_d    = imem_data;
            ipc_d      = pc_q;
            ipc_next_d = pc_plus;
            count_d    = count_q + 32'd1;
            if (halt_hit) begin
                // The halt word itself is delivered; the PC parks on it.
                state_d = HALTED;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_valid   = valid_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc      = ipc_q;
    assign ifid_pc_next = ipc_next_q;
    assign halted       = (state_q == HALTED);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a
// combinational instruction memory model indexed by imem_addr[7:2].
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_next;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".addr"},  imem_addr,            32'h0);
        check({tag, ".valid"}, {31'b0, ifid_valid},  32'h0);
        check({tag, ".instr"}, ifid_instr,           32'h0);
        check({tag, ".pc"},    ifid_pc,              32'h0);
        check({tag, ".pcn"},   ifid_pc_next,         32'h0);
        check({tag, ".halt"},  {31'b0, halted},      32'h0);
        check({tag, ".cnt"},   fetch_count,          32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        idle_inputs();

        // Reset values
        do_reset();
        check_reset_state("rst0");

        // Three free edges
        step();
        check("seq0.pc", ifid_pc, 32'h0);
        check("seq0.instr", ifid_instr, 32'h11);
        check("seq0.valid", {31'b0, ifid_valid}, 32'h1);
        step();
        check("seq1.pc", ifid_pc, 32'h4);
        check("seq1.instr", ifid_instr, 32'h22);
        step();
        check("seq2.pc", ifid_pc, 32'h8);
        check("seq2.instr", ifid_instr, 32'h33);
        check("seq2.pcn", ifid_pc_next, 32'hC);
        check("seq2.cnt", fetch_count, 32'd3);
        check("seq2.addr", imem_addr, 32'hC);

        // Stall two cycles with pc=8
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        check("stall.addr", imem_addr, 32'h8);
        check("stall.pc", ifid_pc, 32'h4);
        check("stall.instr", ifid_instr, 32'h22);
        check("stall.cnt", fetch_count, 32'd2);
        stall = 1'b0;
        step();
        check("unstall.pc", ifid_pc, 32'h8);
        check("unstall.instr", ifid_instr, 32'h33);
        check("unstall.cnt", fetch_count, 32'd3);

        // Redirect together with stall: redirect wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stall          = 1'b1;
        step();
        idle_inputs();
        check("redir.valid", {31'b0, ifid_valid}, 32'h0);
        check("redir.instr", ifid_instr, 32'h0);
        check("redir.addr", imem_addr, 32'h40);
        check("redir.cnt", fetch_count, 32'd3);
        step();
        check("redir2.pc", ifid_pc, 32'h40);
        check("redir2.instr", ifid_instr, 32'h1000_0010);
        check("redir2.valid", {31'b0, ifid_valid}, 32'h1);
        check("redir2.cnt", fetch_count, 32'd4);

        // Flush alone at pc=0x10
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.valid", {31'b0, ifid_valid}, 32'h0);
        check("flush.addr", imem_addr, 32'h14);
        check("flush.cnt", fetch_count, 32'd4);
        step();
        check("postflush.pc", ifid_pc, 32'h14);
        check("postflush.cnt", fetch_count, 32'd5);

        // Flush beats stall: pc still advances
        flush = 1'b1;
        stall = 1'b1;
        step();
        idle_inputs();
        check("flstall.addr", imem_addr, 32'h1C);
        check("flstall.valid", {31'b0, ifid_valid}, 32'h0);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        check("wrap.addr", imem_addr, 32'h0);
        check("wrap.pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap.pcn", ifid_pc_next, 32'h0);
        check("wrap.instr", ifid_instr, 32'h1000_003F);
        check("wrap.cnt", fetch_count, 32'd6);

        // HALT_WORD at 0x0C
        mem[3] = 32'hFFFF_FFFF;
        do_reset();
        step();
        step();
        step();
        step();
        check("halt.instr", ifid_instr, 32'hFFFF_FFFF);
        check("halt.valid", {31'b0, ifid_valid}, 32'h1);
        check("halt.cnt", fetch_count, 32'd4);
`ifdef FETCH_HALT_DETECT_EN
        check("halt.halted", {31'b0, halted}, 32'h1);
        check("halt.addr", imem_addr, 32'hC);
        step();
        check("halt.bub.valid", {31'b0, ifid_valid}, 32'h0);
        check("halt.bub.addr", imem_addr, 32'hC);
        check("halt.bub.cnt", fetch_count, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("halt.flush.addr", imem_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        idle_inputs();
        check("halt.redir.halted", {31'b0, halted}, 32'h0);
        check("halt.redir.addr", imem_addr, 32'h20);
        step();
        check("halt.resume.pc", ifid_pc, 32'h20);
        check("halt.resume.valid", {31'b0, ifid_valid}, 32'h1);
        check("halt.resume.cnt", fetch_count, 32'd5);
        // Re-enter HALTED, then reset out of it
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        step();
        idle_inputs();
        step();
        check("halt2.halted", {31'b0, halted}, 32'h1);
`else
        check("halt.halted", {31'b0, halted}, 32'h0);
        check("halt.addr", imem_addr, 32'h10);
        step();
        check("halt.next.pc", ifid_pc, 32'h10);
        check("halt.next.cnt", fetch_count, 32'd5);
`endif
        do_reset();
        check_reset_state("rst1");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
